arbitro_decodificador: RTL and testbench

- Shares one Hamming(7,4) decoder (Decodificador: 7-bit Entrada, Controle, 4-bit Saida, clocked) between two codeword requesters.
- Accepts one codeword at a time via valid/ready, sequences the decoder, and waits its fixed latency.
- Returns the 4-bit decoded nibble with the requester ID on a response valid/ready channel.
- Round-robin fairness; saturating per-requester completion counters for debug.

---
 rtl/arbitro_pkg.sv | 14 +
 rtl/arbitro_decodificador_rr_arbiter2.sv | 37 +++
 rtl/arbitro_decodificador.sv | 131 +++++++++++++
 tb/tb_arbitro_decodificador.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared constants for the two-requester Hamming decoder arbiter
package arbitro_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Codeword and decoded nibble widths
  localparam int CW_W  = 7;
  localparam int NIB_W = 4;

endpackage

// File: rtl/arbitro_decodificador_rr_arbiter2.sv
// rtl/arbitro_decodificador_rr_arbiter2.sv - two-input round-robin grant with last-grant memory
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_grant0,
  output logic o_grant1
);

  // Requester that won the most recent accepted handshake; 1 so req0 wins the first tie
  logic r_last_grant;

  // Single valid wins outright; on a tie the requester not served last wins
  always_comb begin
    o_grant0 = 1'b0;
    o_grant1 = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_grant0 = r_last_grant;
      o_grant1 = !r_last_grant;
    end else begin
      o_grant0 = i_valid0;
      o_grant1 = i_valid1;
    end
  end

  // Remember the winner only when the handshake actually completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= o_grant1;
    end
  end

endmodule

// File: rtl/arbitro_decodificador.sv
// rtl/arbitro_decodificador.sv - shares one clocked Hamming(7,4) decoder between two requesters
module arbitro_decodificador
  import arbitro_pkg::*;
#(
  parameter int DEC_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             req0_valid,
  input  logic [CW_W-1:0]  req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [CW_W-1:0]  req1_data,
  output logic             req1_ready,
  output logic [CW_W-1:0]  dec_entrada,
  output logic             dec_controle,
  input  logic [NIB_W-1:0] dec_saida,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [NIB_W-1:0] rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int LAT_W = $clog2(DEC_LAT + 1);

  logic [1:0]       r_state;
  logic [LAT_W-1:0] r_wait_cnt;
  logic [CW_W-1:0]  r_entrada;
  logic             r_rsp_id;
  logic [NIB_W-1:0] r_rsp_data;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_in_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;
  logic w_accept;
  logic w_rsp_fire;

  rr_arbiter2 u_rr_arbiter2 (
    .clk      (clk),
    .rst_n    (Reset),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_accept (w_accept),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  // Ready is offered only in IDLE and only to the arbiter's pick
  always_comb begin
    w_in_idle  = (r_state == IDLE);
    req0_ready = w_in_idle && w_grant0;
    req1_ready = w_in_idle && w_grant1;
    w_acc0     = req0_ready && req0_valid;
    w_acc1     = req1_ready && req1_valid;
    w_accept   = w_acc0 || w_acc1;
    w_rsp_fire = (r_state == RESP) && rsp_ready;
  end

  // Sequence accept -> issue -> fixed-latency wait -> hold response until consumed
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_entrada  <= '0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_entrada <= w_acc1 ? req1_data : req0_data;
            r_rsp_id  <= w_acc1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_wait_cnt <= LAT_W'(DEC_LAT);
          r_state    <= WAIT;
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt - LAT_W'(1);
          if (r_wait_cnt == LAT_W'(1)) begin
            r_rsp_data <= dec_saida;
            r_state    <= RESP;
          end
        end
        default: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  // Saturating per-requester completion counters, bumped on response handshake
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_rsp_fire) begin
      if (!r_rsp_id && (r_cnt0 != {CNT_W{1'b1}})) begin
        r_cnt0 <= r_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (r_rsp_id && (r_cnt1 != {CNT_W{1'b1}})) begin
        r_cnt1 <= r_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Output drive derived from registered state
  always_comb begin
    dec_entrada  = r_entrada;
    dec_controle = (r_state == ISSUE) || (r_state == WAIT);
    rsp_valid    = (r_state == RESP);
    rsp_id       = r_rsp_id;
    rsp_data     = r_rsp_data;
    busy         = (r_state != IDLE);
    cnt0         = r_cnt0;
    cnt1         = r_cnt1;
  end

endmodule

// File: tb/tb_arbitro_decodificador.sv
// tb/tb_arbitro_decodificador.sv - directed self-checking bench for arbitro_decodificador
module tb_arbitro_decodificador;

  logic       clk;
  logic       Reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [6:0] req0_data, req1_data, dec_entrada;
  logic       dec_controle, rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0] dec_saida, rsp_data;
  logic [7:0] cnt0, cnt1;

  logic       s_req0_ready, s_req1_valid, s_req1_ready;
  logic [6:0] s_req1_data, s_dec_entrada;
  logic       s_dec_controle, s_rsp_valid, s_rsp_id, s_busy;
  logic [3:0] s_dec_saida, s_rsp_data;
  logic [1:0] s_cnt0, s_cnt1;

  int checks = 0;
  int errors = 0;

  arbitro_decodificador #(.DEC_LAT(2), .CNT_W(8)) dut (
    .clk(clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dec_entrada(dec_entrada), .dec_controle(dec_controle), .dec_saida(dec_saida),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  arbitro_decodificador #(.DEC_LAT(2), .CNT_W(2)) dut_sat (
    .clk(clk), .Reset(Reset),
    .req0_valid(1'b0), .req0_data(7'd0), .req0_ready(s_req0_ready),
    .req1_valid(s_req1_valid), .req1_data(s_req1_data), .req1_ready(s_req1_ready),
    .dec_entrada(s_dec_entrada), .dec_controle(s_dec_controle), .dec_saida(s_dec_saida),
    .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
    .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  // Two-stage decoder model: nibble is the systematic upper four bits of the codeword
  logic [3:0] m_p1, m_p2, s_p1, s_p2;
  always_ff @(posedge clk) begin
    if (dec_controle) begin
      m_p1 <= dec_entrada[6:3];
      m_p2 <= m_p1;
    end
    if (s_dec_controle) begin
      s_p1 <= s_dec_entrada[6:3];
      s_p2 <= s_p1;
    end
  end
  assign dec_saida   = m_p2;
  assign s_dec_saida = s_p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, req0_ready, req1_ready, rsp_valid, dec_controle, rsp_id} !== 6'b0 ||
        dec_entrada !== 7'd0 || rsp_data !== 4'd0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rdy=%b%b rv=%b ctl=%b ent=%h cnt0=%0d cnt1=%0d expected all 0",
               busy, req0_ready, req1_ready, rsp_valid, dec_controle, dec_entrada, cnt0, cnt1);
    end
    Reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, req0_ready, req1_ready, rsp_valid, dec_controle} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b rdy=%b%b rv=%b ctl=%b expected 0",
               busy, req0_ready, req1_ready, rsp_valid, dec_controle);
    end
  endtask

  task automatic test_single();
    int n;
    req0_data = 7'b1100000; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: rdy0=%b rdy1=%b expected 1 0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    n = 1;
    checks++;
    if (dec_controle !== 1'b1 || dec_entrada !== 7'b1100000) begin
      errors++;
      $display("FAIL single_issue: ctl=%b ent=%b expected 1 1100000", dec_controle, dec_entrada);
    end
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles expected 4", n);
    end
    checks++;
    if (rsp_id !== 1'b0 || rsp_data !== 4'b1100 || dec_controle !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: id=%b data=%b ctl=%b expected 0 1100 0", rsp_id, rsp_data, dec_controle);
    end
    @(negedge clk);
    checks++;
    if (cnt0 !== 8'd1 || cnt1 !== 8'd0 || busy !== 1'b0 || dec_entrada !== 7'b1100000) begin
      errors++;
      $display("FAIL single_count: cnt0=%0d cnt1=%0d busy=%b ent=%b expected 1 0 0 1100000",
               cnt0, cnt1, busy, dec_entrada);
    end
  endtask

  task automatic test_alternate();
    int n;
    logic exp_id;
    logic [3:0] exp_data;
    Reset = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    req0_data = 7'b1001001; req1_data = 7'b1000100;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_id   = t[0];
      exp_data = exp_id ? 4'b1000 : 4'b1001;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data) begin
        errors++;
        $display("FAIL alternate_txn%0d: rv=%b id=%b data=%b expected 1 %b %b",
                 t, rsp_valid, rsp_id, rsp_data, exp_id, exp_data);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL alternate_counts: cnt0=%0d cnt1=%0d expected 2 2", cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure();
    int n;
    req1_data = 7'b1000100; req1_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d cycles expected 4", n);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 4'b1000 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || cnt1 !== 8'd2) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b id=%b data=%b rdy=%b%b cnt1=%0d expected 1 1 1000 00 2",
                 i, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, cnt1);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt1 !== 8'd3 || cnt0 !== 8'd2 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: cnt0=%0d cnt1=%0d rv=%b busy=%b expected 2 3 0 0",
               cnt0, cnt1, rsp_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    int seen;
    req0_data = 7'b1100000; req0_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dec_controle !== 1'b0 || rsp_valid !== 1'b0 ||
        cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL midreset_clear: busy=%b ctl=%b rv=%b cnt0=%0d cnt1=%0d expected 0",
               busy, dec_controle, rsp_valid, cnt0, cnt1);
    end
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_dropped: saw activity on %0d cycles expected 0", seen);
    end
    req1_data = 7'b1001001; req1_valid = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== 4 || rsp_id !== 1'b1 || rsp_data !== 4'b1001) begin
      errors++;
      $display("FAIL midreset_next: lat=%0d id=%b data=%b expected 4 1 1001", n, rsp_id, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL midreset_counts: cnt0=%0d cnt1=%0d expected 0 1", cnt0, cnt1);
    end
  endtask

  task automatic test_saturate();
    int n;
    logic [1:0] exp_cnt;
    s_req1_data = 7'b1000100; s_req1_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!s_rsp_valid && n < 20);
      if (k == 5) s_req1_valid = 1'b0;
      @(negedge clk);
      exp_cnt = (k > 3) ? 2'd3 : k[1:0];
      checks++;
      if (n >= 20 || s_cnt1 !== exp_cnt || s_cnt0 !== 2'd0) begin
        errors++;
        $display("FAIL saturate_k%0d: wait=%0d cnt1=%0d cnt0=%0d expected cnt1 %0d cnt0 0",
                 k, n, s_cnt1, s_cnt0, exp_cnt);
      end
    end
  endtask

  initial begin
    Reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 7'd0; req1_data = 7'd0;
    rsp_ready = 1'b0;
    s_req1_valid = 1'b0; s_req1_data = 7'd0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_mid_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
